// File: rtl/demod.sv
// rtl/demod.sv - 5-bit symbol to 8-bit byte repacker with valid/ack output, flush and overflow
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   dmod      incoming 5-bit symbol, valid when mod_en=1
//   mod_en    symbol strobe (cannot be back-pressured)
//   ack       sink accepts data_out this cycle (only meaningful with wr=1)
//   flush     level request to emit a partial, zero-padded byte
//   data_out  assembled byte, LSB-first
//   wr        data_out valid; held with data_out stable until ack
//   ovf       sticky: a symbol was dropped because the accumulator was full
//   cnt       number of valid bits in the accumulator
module demod #(
    parameter int ACC_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] dmod,
    input  logic       mod_en,
    input  logic       ack,
    input  logic       flush,
    output logic [7:0] data_out,
    output logic       wr,
    output logic       ovf,
    output logic [4:0] cnt
);

    localparam logic [5:0] ACC_LIM = 6'(ACC_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_b;
    logic [ACC_W-1:0] acc_n;
    logic [ACC_W-1:0] sym_ext;
    logic [4:0]       cnt_b;
    logic [4:0]       cnt_n;
    logic [7:0]       data_n;
    logic             wr_n;
    logic             ovf_n;
    logic             free;
    logic             take;
    logic             accept;
    logic             flush_ok;

    always_comb begin
        // The output slot is free if empty or being emptied this cycle, so a
        // new byte can load in the same cycle the previous one is acked.
        free     = !wr || ack;
        take     = (cnt >= 5'd8) && free;
        acc_b    = take ? (acc >> 8) : acc;
        cnt_b    = take ? (cnt - 5'd8) : cnt;
        // A symbol landing in the same cycle as a take goes in at cnt-8.
        accept   = mod_en && (({1'b0, cnt_b} + 6'd5) <= ACC_LIM);
        // Flush only when no symbol arrives, so it never splits a symbol.
        flush_ok = flush && (cnt != 5'd0) && (cnt < 5'd8) && free && !mod_en;
        sym_ext  = {{(ACC_W-5){1'b0}}, dmod};

        acc_n  = acc_b;
        cnt_n  = cnt_b;
        data_n = data_out;
        wr_n   = wr;
        ovf_n  = ovf;

        if (accept) begin
            acc_n = acc_b | (sym_ext << cnt_b);
            cnt_n = cnt_b + 5'd5;
        end else if (mod_en) begin
            ovf_n = 1'b1;
        end

        if (flush_ok) begin
            // Bits above cnt are always zero, so acc[7:0] is already padded.
            data_n = acc[7:0];
            wr_n   = 1'b1;
            acc_n  = '0;
            cnt_n  = 5'd0;
        end else if (take) begin
            data_n = acc[7:0];
            wr_n   = 1'b1;
        end else if (ack && wr) begin
            wr_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= 5'd0;
            data_out <= 8'h00;
            wr       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            acc      <= acc_n;
            cnt      <= cnt_n;
            data_out <= data_n;
            wr       <= wr_n;
            ovf      <= ovf_n;
        end
    end

endmodule

// File: tb/tb_demod.sv
// tb/tb_demod.sv - directed scoreboard testbench for demod
module tb_demod;

    logic       clk;
    logic       rst_n;
    logic [4:0] dmod;
    logic       mod_en;
    logic       ack;
    logic       flush;
    logic [7:0] data_out;
    logic       wr;
    logic       ovf;
    logic [4:0] cnt;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    demod #(.ACC_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dmod     (dmod),
        .mod_en   (mod_en),
        .ack      (ack),
        .flush    (flush),
        .data_out (data_out),
        .wr       (wr),
        .ovf      (ovf),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then advance past the next rising edge.
    task automatic drive(input logic [4:0] s, input logic en, input logic f);
        dmod   = s;
        mod_en = en;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    // A byte is consumed at the next edge whenever wr && ack; compare it there.
    always @(negedge clk) begin
        if (rst_n && wr && ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {8'h00, data_out}, 16'hFFFF);
            end else begin
                chk("byte", {8'h00, data_out}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        dmod     = 5'h00;
        mod_en   = 1'b0;
        ack      = 1'b1;
        flush    = 1'b0;

        #3;
        chk("rst_wr", {15'h0, wr}, 16'h0);
        chk("rst_cnt", {11'h0, cnt}, 16'h0);
        chk("rst_data", {8'h0, data_out}, 16'h0);
        chk("rst_ovf", {15'h0, ovf}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 05,05,0F -> A5 one cycle after the second symbol, cnt=7
        exp_q.push_back(8'hA5);
        drive(5'h05, 1'b1, 1'b0);
        drive(5'h05, 1'b1, 1'b0);
        chk("t1_wr_early", {15'h0, wr}, 16'h0);
        drive(5'h0F, 1'b1, 1'b0);
        chk("t1_wr", {15'h0, wr}, 16'h1);
        chk("t1_data", {8'h0, data_out}, 16'h00A5);
        chk("t1_cnt", {11'h0, cnt}, 16'd7);

        // flush the remaining 7 bits -> 3C
        exp_q.push_back(8'h3C);
        drive(5'h00, 1'b0, 1'b1);
        chk("t2_wr", {15'h0, wr}, 16'h1);
        chk("t2_data", {8'h0, data_out}, 16'h003C);
        chk("t2_cnt", {11'h0, cnt}, 16'd0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t2_wr_drop", {15'h0, wr}, 16'h0);

        // 8 symbols of 1F -> 5 bytes of FF
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) drive(5'h1F, 1'b1, 1'b0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t3_cnt", {11'h0, cnt}, 16'd0);
        chk("t3_ovf", {15'h0, ovf}, 16'h0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t3_drained", 16'(exp_q.size()), 16'd0);

        // stall with ack=0: 5,10,7(byte out),12, then a dropped symbol
        ack = 1'b0;
        exp_q.push_back(8'hFF);
        drive(5'h1F, 1'b1, 1'b0);
        drive(5'h1F, 1'b1, 1'b0);
        drive(5'h1F, 1'b1, 1'b0);
        chk("t4_wr", {15'h0, wr}, 16'h1);
        chk("t4_cnt7", {11'h0, cnt}, 16'd7);
        drive(5'h1F, 1'b1, 1'b0);
        chk("t4_cnt12", {11'h0, cnt}, 16'd12);
        chk("t4_ovf0", {15'h0, ovf}, 16'h0);
        chk("t4_stable", {8'h0, data_out}, 16'h00FF);
        drive(5'h1F, 1'b1, 1'b0);
        chk("t4_ovf1", {15'h0, ovf}, 16'h1);
        chk("t4_cnt_hold", {11'h0, cnt}, 16'd12);
        chk("t4_wr_hold", {15'h0, wr}, 16'h1);
        // release: second FF loads on the ack edge with no bubble
        ack = 1'b1;
        exp_q.push_back(8'hFF);
        drive(5'h00, 1'b0, 1'b0);
        chk("t4_nobubble", {15'h0, wr}, 16'h1);
        chk("t4_cnt4", {11'h0, cnt}, 16'd4);
        drive(5'h00, 1'b0, 1'b0);
        chk("t4_wr_off", {15'h0, wr}, 16'h0);
        chk("t4_ovf_sticky", {15'h0, ovf}, 16'h1);
        exp_q.push_back(8'h0F);
        drive(5'h00, 1'b0, 1'b1);
        chk("t4_flush", {8'h0, data_out}, 16'h000F);
        drive(5'h00, 1'b0, 1'b0);

        // async reset mid-cycle while cnt=7 and wr=1 (ack low so it is not consumed)
        drive(5'h05, 1'b1, 1'b0);
        drive(5'h05, 1'b1, 1'b0);
        ack = 1'b0;
        drive(5'h0F, 1'b0 | 1'b1, 1'b0);
        mod_en = 1'b0;
        chk("t5_pre_wr", {15'h0, wr}, 16'h1);
        chk("t5_pre_cnt", {11'h0, cnt}, 16'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr", {15'h0, wr}, 16'h0);
        chk("t5_cnt", {11'h0, cnt}, 16'h0);
        chk("t5_data", {8'h0, data_out}, 16'h0);
        chk("t5_ovf", {15'h0, ovf}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack   = 1'b1;
        exp_q.push_back(8'hA5);
        drive(5'h05, 1'b1, 1'b0);
        drive(5'h05, 1'b1, 1'b0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t5_post_data", {8'h0, data_out}, 16'h00A5);
        chk("t5_post_cnt", {11'h0, cnt}, 16'd2);

        // flush with 2 zero bits -> 00
        exp_q.push_back(8'h00);
        drive(5'h00, 1'b0, 1'b1);
        chk("t6_pad_wr", {15'h0, wr}, 16'h1);
        chk("t6_pad_cnt", {11'h0, cnt}, 16'd0);

        // 7 x 1F + idle -> 4 FF bytes, cnt=3
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 7; i++) drive(5'h1F, 1'b1, 1'b0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t6_cnt3", {11'h0, cnt}, 16'd3);
        // flush together with a symbol: flush ignored, 3 ones + 0A<<3 = 57
        exp_q.push_back(8'h57);
        drive(5'h0A, 1'b1, 1'b1);
        chk("t6_cnt8", {11'h0, cnt}, 16'd8);
        drive(5'h00, 1'b0, 1'b0);
        chk("t6_byte_wr", {15'h0, wr}, 16'h1);
        chk("t6_byte", {8'h0, data_out}, 16'h0057);
        chk("t6_cnt0", {11'h0, cnt}, 16'd0);
        drive(5'h00, 1'b0, 1'b0);
        chk("t6_wr_off", {15'h0, wr}, 16'h0);
        drive(5'h00, 1'b0, 1'b0);
        chk("all_bytes_seen", 16'(exp_q.size()), 16'd0);
        chk("ovf_final", {15'h0, ovf}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
